gpu_pll_reset_sequencer: RTL and testbench

- Supervises the GPU PLL (50 MHz ref -> 25 MHz pixel, 100 MHz core). Runs on the free-running 50 MHz reference clock.
- Drives the PLL reset, watches its lock output, and issues staged reset requests for the two PLL output domains. The core is released first, then the pixel/scanout domain.
- Retries the PLL on lock timeout. Flags a permanent failure after a retry budget is spent.
- Per-domain reset synchronisers live in the consuming domains.

---
 rtl/gpu_clk_pkg.sv | 30 +++
 rtl/gpu_sync_bit.sv | 20 ++
 rtl/gpu_pll_reset_sequencer.sv | 154 +++++++++++++++
 tb/tb_gpu_pll_reset_sequencer.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_clk_pkg.sv
// Shared types and timing defaults for the GPU clock/reset supervision blocks.
package gpu_clk_pkg;

  typedef enum logic [2:0] {
    PLL_RESET,
    WAIT_LOCK,
    LOCK_STABLE,
    RELEASE_CORE,
    RUN,
    FAIL
  } seq_state_e;

  localparam int DEF_SYNC_STAGES        = 2;
  localparam int DEF_PLL_RST_CYCLES     = 16;
  localparam int DEF_LOCK_TIMEOUT       = 50000;
  localparam int DEF_LOCK_STABLE_CYCLES = 1024;
  localparam int DEF_STAGGER_CYCLES     = 64;
  localparam int DEF_RETRY_LIMIT        = 7;

  // Counter only ever holds (largest count - 1), so clog2 of the largest count is enough.
  function automatic int cnt_width(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/gpu_sync_bit.sv
// N-flop single-bit synchroniser with synchronous clear.
module gpu_sync_bit #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic clr,
  input  logic d,
  output logic q
);

  logic [N-1:0] sr;

  always_ff @(posedge clk) begin
    if (clr) sr <= '0;
    else     sr <= (sr << 1) | N'(d);
  end

  assign q = sr[N-1];

endmodule

// File: rtl/gpu_pll_reset_sequencer.sv
// PLL supervisor on refclk: pulses the PLL reset, waits for stable lock, then
// releases the core domain and, after a stagger, the pixel domain.
module gpu_pll_reset_sequencer
  import gpu_clk_pkg::*;
#(
  parameter int SYNC_STAGES        = DEF_SYNC_STAGES,
  parameter int PLL_RST_CYCLES     = DEF_PLL_RST_CYCLES,
  parameter int LOCK_TIMEOUT       = DEF_LOCK_TIMEOUT,
  parameter int LOCK_STABLE_CYCLES = DEF_LOCK_STABLE_CYCLES,
  parameter int STAGGER_CYCLES     = DEF_STAGGER_CYCLES,
  parameter int RETRY_LIMIT        = DEF_RETRY_LIMIT
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       soft_reset_req,
  input  logic       pll_locked,
  output logic       pll_rst,
  output logic       core_rst_req,
  output logic       pix_rst_req,
  output logic       ready,
  output logic       lock_fail,
  output logic [3:0] retry_count
);

  localparam int CW = cnt_width(PLL_RST_CYCLES, LOCK_TIMEOUT, LOCK_STABLE_CYCLES, STAGGER_CYCLES);
  localparam logic [CW-1:0] RST_LAST = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STB_LAST = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0] STG_LAST = CW'(STAGGER_CYCLES - 1);
  localparam logic [3:0]    RLIM     = 4'(RETRY_LIMIT);

  logic          locked_s;
  seq_state_e    state;
  logic [CW-1:0] cnt;
  logic [3:0]    retry_nxt;

  gpu_sync_bit #(.N(SYNC_STAGES)) u_lock_sync (
    .clk (refclk),
    .clr (rst),
    .d   (pll_locked),
    .q   (locked_s)
  );

  assign retry_nxt = retry_count + 4'd1;

  always_ff @(posedge refclk) begin
    if (rst) begin
      state        <= PLL_RESET;
      cnt          <= '0;
      pll_rst      <= 1'b1;
      core_rst_req <= 1'b1;
      pix_rst_req  <= 1'b1;
      ready        <= 1'b0;
      lock_fail    <= 1'b0;
      retry_count  <= 4'd0;
    end else if (soft_reset_req) begin
      state        <= PLL_RESET;
      cnt          <= '0;
      pll_rst      <= 1'b1;
      core_rst_req <= 1'b1;
      pix_rst_req  <= 1'b1;
      ready        <= 1'b0;
      if (state == FAIL) begin
        lock_fail   <= 1'b0;
        retry_count <= 4'd0;
      end
    end else begin
      case (state)
        PLL_RESET: begin
          if (cnt == RST_LAST) begin
            state   <= WAIT_LOCK;
            cnt     <= '0;
            pll_rst <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_LOCK: begin
          // A lock arriving on the timeout cycle beats the retry.
          if (locked_s) begin
            state <= LOCK_STABLE;
            cnt   <= '0;
          end else if (cnt == TO_LAST) begin
            retry_count <= retry_nxt;
            cnt         <= '0;
            pll_rst     <= 1'b1;
            if (retry_nxt == RLIM) begin
              state     <= FAIL;
              lock_fail <= 1'b1;
            end else begin
              state <= PLL_RESET;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        LOCK_STABLE: begin
          if (!locked_s) begin
            state <= WAIT_LOCK;
            cnt   <= '0;
          end else if (cnt == STB_LAST) begin
            state        <= RELEASE_CORE;
            cnt          <= '0;
            core_rst_req <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RELEASE_CORE: begin
          if (!locked_s) begin
            state        <= PLL_RESET;
            cnt          <= '0;
            pll_rst      <= 1'b1;
            core_rst_req <= 1'b1;
          end else if (cnt == STG_LAST) begin
            state       <= RUN;
            cnt         <= '0;
            pix_rst_req <= 1'b0;
            ready       <= 1'b1;
            retry_count <= 4'd0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RUN: begin
          if (!locked_s) begin
            state        <= PLL_RESET;
            cnt          <= '0;
            pll_rst      <= 1'b1;
            core_rst_req <= 1'b1;
            pix_rst_req  <= 1'b1;
            ready        <= 1'b0;
          end
        end
        FAIL: begin
          pll_rst      <= 1'b1;
          core_rst_req <= 1'b1;
          pix_rst_req  <= 1'b1;
          ready        <= 1'b0;
          lock_fail    <= 1'b1;
        end
        default: begin
          state        <= PLL_RESET;
          cnt          <= '0;
          pll_rst      <= 1'b1;
          core_rst_req <= 1'b1;
          pix_rst_req  <= 1'b1;
          ready        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gpu_pll_reset_sequencer.sv
// Directed bench: stimulus queues expected output vectors per edge; a negedge monitor checks them.
module tb_gpu_pll_reset_sequencer;

  logic       refclk = 1'b0;
  logic       rst = 1'b1;
  logic       soft_reset_req = 1'b0;
  logic       pll_locked = 1'b0;
  logic       pll_rst, core_rst_req, pix_rst_req, ready, lock_fail;
  logic [3:0] retry_count;

  gpu_pll_reset_sequencer #(
    .SYNC_STAGES        (2),
    .PLL_RST_CYCLES     (4),
    .LOCK_TIMEOUT       (100),
    .LOCK_STABLE_CYCLES (8),
    .STAGGER_CYCLES     (3),
    .RETRY_LIMIT        (2)
  ) dut (
    .refclk         (refclk),
    .rst            (rst),
    .soft_reset_req (soft_reset_req),
    .pll_locked     (pll_locked),
    .pll_rst        (pll_rst),
    .core_rst_req   (core_rst_req),
    .pix_rst_req    (pix_rst_req),
    .ready          (ready),
    .lock_fail      (lock_fail),
    .retry_count    (retry_count)
  );

  always #5 refclk = ~refclk;

  int cyc = 0;
  always @(posedge refclk) cyc <= cyc + 1;

  typedef struct {
    int         t;
    int         tid;
    int         rel;
    logic [8:0] e;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   g0 = 0;
  int   tid = 0;

  // {pll_rst, core_rst_req, pix_rst_req, ready, lock_fail, retry_count}
  function automatic logic [8:0] v(input bit pr, input bit cr, input bit px,
                                   input bit rd, input bit lf, input int rc);
    return {pr, cr, px, rd, lf, 4'(rc)};
  endfunction

  task automatic expect_at(input int rel, input logic [8:0] e);
    q.push_back('{t: g0 + rel, tid: tid, rel: rel, e: e});
  endtask

  task automatic go_to(input int rel);
    while (cyc < g0 + rel) @(negedge refclk);
  endtask

  task automatic do_reset();
    int r;
    @(negedge refclk);
    rst = 1'b1;
    soft_reset_req = 1'b0;
    pll_locked = 1'b0;
    r = cyc;
    q.push_back('{t: r + 1, tid: tid, rel: 0, e: v(1, 1, 1, 0, 0, 0)});
    @(negedge refclk);
    @(negedge refclk);
    g0 = r + 1;
    rst = 1'b0;
  endtask

  task automatic drain();
    @(negedge refclk);
    for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge refclk);
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain_t%0d: %0d expectations never checked, required 0", tid, q.size());
      q.delete();
    end
  endtask

  logic [8:0] obs;
  exp_t       x;
  always @(negedge refclk) begin
    obs = {pll_rst, core_rst_req, pix_rst_req, ready, lock_fail, retry_count};
    checks++;
    if (!pix_rst_req && core_rst_req) begin
      errors++;
      $display("FAIL inv_pix_core @edge %0d: pix_rst_req=0 core_rst_req=%b required 0", cyc - 1, core_rst_req);
    end
    checks++;
    if (ready !== !pix_rst_req) begin
      errors++;
      $display("FAIL inv_ready @edge %0d: ready=%b required %b", cyc - 1, ready, !pix_rst_req);
    end
    checks++;
    if (pll_rst && !(core_rst_req && pix_rst_req)) begin
      errors++;
      $display("FAIL inv_pllrst @edge %0d: rst_req=%b%b required 11", cyc - 1, core_rst_req, pix_rst_req);
    end
    while (q.size() > 0 && q[0].t <= cyc - 1) begin
      x = q.pop_front();
      checks++;
      if (x.t < cyc - 1) begin
        errors++;
        $display("FAIL t%0d_e%0d: missed, seen at edge %0d required edge %0d", x.tid, x.rel, cyc - 1, x.t);
      end else if (obs !== x.e) begin
        errors++;
        $display("FAIL t%0d_e%0d: got %b required %b (pllrst,core,pix,ready,fail,retry[4])",
                 x.tid, x.rel, obs, x.e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, queue depth %0d required 0", q.size());
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: nominal bring-up
    tid = 1;
    do_reset();
    expect_at(1,  v(1, 1, 1, 0, 0, 0));
    expect_at(3,  v(1, 1, 1, 0, 0, 0));
    expect_at(4,  v(0, 1, 1, 0, 0, 0));
    expect_at(29, v(0, 1, 1, 0, 0, 0));
    expect_at(30, v(0, 0, 1, 0, 0, 0));
    expect_at(32, v(0, 0, 1, 0, 0, 0));
    expect_at(33, v(0, 0, 0, 1, 0, 0));
    expect_at(40, v(0, 0, 0, 1, 0, 0));
    go_to(20); pll_locked = 1'b1;
    go_to(41);
    drain();

    // 2: lock glitch during LOCK_STABLE
    tid = 2;
    do_reset();
    expect_at(4,  v(0, 1, 1, 0, 0, 0));
    expect_at(26, v(0, 1, 1, 0, 0, 0));
    expect_at(30, v(0, 1, 1, 0, 0, 0));
    expect_at(35, v(0, 1, 1, 0, 0, 0));
    expect_at(45, v(0, 1, 1, 0, 0, 0));
    expect_at(49, v(0, 1, 1, 0, 0, 0));
    expect_at(50, v(0, 0, 1, 0, 0, 0));
    expect_at(53, v(0, 0, 0, 1, 0, 0));
    go_to(20); pll_locked = 1'b1;
    go_to(25); pll_locked = 1'b0;
    go_to(40); pll_locked = 1'b1;
    go_to(54);
    drain();

    // 3: timeouts to FAIL, then soft reset recovery
    tid = 3;
    do_reset();
    expect_at(3,   v(1, 1, 1, 0, 0, 0));
    expect_at(4,   v(0, 1, 1, 0, 0, 0));
    expect_at(103, v(0, 1, 1, 0, 0, 0));
    expect_at(104, v(1, 1, 1, 0, 0, 1));
    expect_at(107, v(1, 1, 1, 0, 0, 1));
    expect_at(108, v(0, 1, 1, 0, 0, 1));
    expect_at(207, v(0, 1, 1, 0, 0, 1));
    expect_at(208, v(1, 1, 1, 0, 1, 2));
    expect_at(259, v(1, 1, 1, 0, 1, 2));
    expect_at(260, v(1, 1, 1, 0, 0, 0));
    expect_at(263, v(1, 1, 1, 0, 0, 0));
    expect_at(264, v(0, 1, 1, 0, 0, 0));
    go_to(260); soft_reset_req = 1'b1;
    go_to(261); soft_reset_req = 1'b0;
    go_to(265);
    drain();

    // 4: lock loss in RUN, then re-sequence
    tid = 4;
    do_reset();
    expect_at(33, v(0, 0, 0, 1, 0, 0));
    expect_at(41, v(0, 0, 0, 1, 0, 0));
    expect_at(42, v(1, 1, 1, 0, 0, 0));
    expect_at(45, v(1, 1, 1, 0, 0, 0));
    expect_at(46, v(0, 1, 1, 0, 0, 0));
    expect_at(59, v(0, 1, 1, 0, 0, 0));
    expect_at(60, v(0, 0, 1, 0, 0, 0));
    expect_at(63, v(0, 0, 0, 1, 0, 0));
    go_to(20); pll_locked = 1'b1;
    go_to(40); pll_locked = 1'b0;
    go_to(50); pll_locked = 1'b1;
    go_to(64);
    drain();

    // 5: soft reset coincident with lock loss in RUN; rst mid-LOCK_STABLE
    tid = 5;
    do_reset();
    expect_at(39, v(0, 0, 0, 1, 0, 0));
    expect_at(40, v(1, 1, 1, 0, 0, 0));
    expect_at(43, v(1, 1, 1, 0, 0, 0));
    expect_at(44, v(0, 1, 1, 0, 0, 0));
    expect_at(60, v(0, 1, 1, 0, 0, 0));
    expect_at(74, v(0, 1, 1, 0, 0, 0));
    expect_at(75, v(1, 1, 1, 0, 0, 0));
    expect_at(78, v(1, 1, 1, 0, 0, 0));
    expect_at(79, v(0, 1, 1, 0, 0, 0));
    expect_at(87, v(0, 1, 1, 0, 0, 0));
    expect_at(88, v(0, 0, 1, 0, 0, 0));
    go_to(20); pll_locked = 1'b1;
    go_to(38); pll_locked = 1'b0;
    go_to(40); soft_reset_req = 1'b1;
    go_to(41); soft_reset_req = 1'b0;
    go_to(70); pll_locked = 1'b1;
    go_to(75); rst = 1'b1;
    go_to(76); rst = 1'b0;
    go_to(89);
    drain();

    // 6: lock arriving on the timeout cycle wins; RUN clears retry_count
    tid = 6;
    do_reset();
    expect_at(104, v(1, 1, 1, 0, 0, 1));
    expect_at(108, v(0, 1, 1, 0, 0, 1));
    expect_at(207, v(0, 1, 1, 0, 0, 1));
    expect_at(208, v(0, 1, 1, 0, 0, 1));
    expect_at(215, v(0, 1, 1, 0, 0, 1));
    expect_at(216, v(0, 0, 1, 0, 0, 1));
    expect_at(218, v(0, 0, 1, 0, 0, 1));
    expect_at(219, v(0, 0, 0, 1, 0, 0));
    go_to(206); pll_locked = 1'b1;
    go_to(220);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
